// File: rtl/reg_file_wb_if.sv
// Writeback/read bus between the EXE/WB path, the decode stage and the register file.
// ren is a one-shot request with no ready: the file accepts every request, and rvalid
// pulses for exactly one cycle, one edge after ren was sampled high.
interface reg_file_wb_if #(
  parameter int DSIZE = 16,
  parameter int ASIZE = 3
);
  logic             wen;
  logic [ASIZE-1:0] waddr;
  logic [DSIZE-1:0] wdata;
  logic             ren;
  logic [ASIZE-1:0] raddr_a;
  logic [ASIZE-1:0] raddr_b;
  logic [DSIZE-1:0] rdata_a;
  logic [DSIZE-1:0] rdata_b;
  logic             rvalid;

  modport master (
    output wen, waddr, wdata, ren, raddr_a, raddr_b,
    input  rdata_a, rdata_b, rvalid
  );

  modport slave (
    input  wen, waddr, wdata, ren, raddr_a, raddr_b,
    output rdata_a, rdata_b, rvalid
  );
endinterface

// File: rtl/reg_file_wb.sv
// Architectural register file with two registered read ports and write-first bypass.
// Register 0 reads as zero and ignores writes.
module reg_file_wb #(
  parameter int DSIZE = 16,
  parameter int ASIZE = 3
) (
  input logic         clk,
  input logic         rst,
  reg_file_wb_if.slave bus
);
  localparam int NREG = 1 << ASIZE;

  logic [DSIZE-1:0] mem [NREG];
  logic [DSIZE-1:0] rd_a;
  logic [DSIZE-1:0] rd_b;

  // Bypass first, then the r0 override so address 0 wins even against a same-cycle write.
  always_comb begin
    rd_a = mem[bus.raddr_a];
    if (bus.wen && (bus.waddr == bus.raddr_a)) rd_a = bus.wdata;
    if (bus.raddr_a == '0) rd_a = '0;

    rd_b = mem[bus.raddr_b];
    if (bus.wen && (bus.waddr == bus.raddr_b)) rd_b = bus.wdata;
    if (bus.raddr_b == '0) rd_b = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (bus.wen && (bus.waddr != '0)) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rdata_a <= '0;
      bus.rdata_b <= '0;
      bus.rvalid  <= 1'b0;
    end else begin
      bus.rvalid <= bus.ren;
      if (bus.ren) begin
        bus.rdata_a <= rd_a;
        bus.rdata_b <= rd_b;
      end
    end
  end
endmodule

// File: tb/tb_reg_file_wb.sv
// Directed and randomized checks of reg_file_wb against an array-based model of the
// architectural register state and the registered read outputs.
module tb_reg_file_wb;
  localparam int DSIZE = 16;
  localparam int ASIZE = 3;
  localparam int NREG  = 1 << ASIZE;
  localparam int EW    = 2 * DSIZE + 1;

  logic clk;
  logic rst;

  reg_file_wb_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) bus ();

  reg_file_wb #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state and scoreboard
  logic [DSIZE-1:0] ref_mem [NREG];
  logic [DSIZE-1:0] exp_a;
  logic [DSIZE-1:0] exp_b;
  logic             exp_v;
  logic [EW-1:0]    exp_q[$];
  int n_cmp;
  int n_bad;

  function automatic logic [DSIZE-1:0] model_read(
    input logic [ASIZE-1:0] ra, input logic w_en,
    input logic [ASIZE-1:0] wa, input logic [DSIZE-1:0] wd);
    if (ra == 0) return '0;
    if (w_en && wa == ra) return wd;
    return ref_mem[ra];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) ref_mem[i] = '0;
    exp_a = '0;
    exp_b = '0;
    exp_v = 1'b0;
  endtask

  task automatic check(input string tag, input logic [DSIZE-1:0] obs,
                       input logic [DSIZE-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver: one clock edge with the given bus values, then score the outputs
  task automatic step(input string tag, input logic w_en, input logic [ASIZE-1:0] wa,
                      input logic [DSIZE-1:0] wd, input logic r_en,
                      input logic [ASIZE-1:0] ra, input logic [ASIZE-1:0] rb);
    logic [EW-1:0] e;
    @(negedge clk);
    bus.wen = w_en; bus.waddr = wa; bus.wdata = wd;
    bus.ren = r_en; bus.raddr_a = ra; bus.raddr_b = rb;
    if (r_en) begin
      exp_a = model_read(ra, w_en, wa, wd);
      exp_b = model_read(rb, w_en, wa, wd);
      exp_v = 1'b1;
    end else begin
      exp_v = 1'b0;
    end
    if (w_en && wa != 0) ref_mem[wa] = wd;
    exp_q.push_back({exp_v, exp_a, exp_b});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, ".rdata_a"}, bus.rdata_a, e[2*DSIZE-1:DSIZE]);
    check({tag, ".rdata_b"}, bus.rdata_b, e[DSIZE-1:0]);
    check({tag, ".rvalid"}, {15'd0, bus.rvalid}, {15'd0, e[EW-1]});
  endtask

  task automatic idle();
    bus.wen = 1'b0; bus.waddr = '0; bus.wdata = '0;
    bus.ren = 1'b0; bus.raddr_a = '0; bus.raddr_b = '0;
  endtask

  initial begin
    logic [DSIZE-1:0] v;
    n_cmp = 0;
    n_bad = 0;
    idle();
    model_reset();
    rst = 1'b1;
    #1;
    check("por.rdata_a", bus.rdata_a, '0);
    check("por.rdata_b", bus.rdata_b, '0);
    check("por.rvalid", {15'd0, bus.rvalid}, '0);
    #20;
    @(negedge clk);
    rst = 1'b0;

    // basic write then read
    step("wr_r3", 1'b1, 3'd3, 16'hA5A5, 1'b0, 3'd0, 3'd0);
    step("rd_r3", 1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 3'd0);

    // bypass: both ports see the same-edge write
    step("wr_r5", 1'b1, 3'd5, 16'h0042, 1'b0, 3'd0, 3'd0);
    step("byp_r5", 1'b1, 3'd5, 16'h1234, 1'b1, 3'd5, 3'd5);
    step("rd_r5", 1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 3'd3);

    // r0 protection, stored and bypassed
    step("wr_r0", 1'b1, 3'd0, 16'hFFFF, 1'b0, 3'd0, 3'd0);
    step("rd_r0", 1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 3'd0);
    step("byp_r0", 1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0, 3'd3);

    // hold while ren is low, write lands meanwhile
    step("hold_rd", 1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 3'd5);
    step("hold_1", 1'b1, 3'd3, 16'h0001, 1'b0, 3'd3, 3'd3);
    step("hold_2", 1'b0, 3'd0, 16'h0000, 1'b0, 3'd1, 3'd2);
    step("hold_3", 1'b0, 3'd0, 16'h0000, 1'b0, 3'd4, 3'd6);
    step("hold_rd2", 1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 3'd0);

    // full sweep
    for (int i = 1; i < NREG; i++) begin
      v = DSIZE'(16'h1111 * i);
      step("sweep_wr", 1'b1, ASIZE'(i), v, 1'b0, 3'd0, 3'd0);
    end
    step("sweep_17", 1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 3'd7);
    step("sweep_26", 1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 3'd6);
    step("sweep_35", 1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 3'd5);

    // asynchronous reset between edges, with a write pending on the bus
    @(negedge clk);
    bus.wen = 1'b1; bus.waddr = 3'd4; bus.wdata = 16'hBEEF;
    bus.ren = 1'b1; bus.raddr_a = 3'd4; bus.raddr_b = 3'd7;
    rst = 1'b1;
    #2;
    check("arst.rdata_a", bus.rdata_a, '0);
    check("arst.rdata_b", bus.rdata_b, '0);
    check("arst.rvalid", {15'd0, bus.rvalid}, '0);
    model_reset();
    // hold reset across an edge: the pending write and read must be discarded
    @(posedge clk);
    #1;
    check("arst_edge.rdata_a", bus.rdata_a, '0);
    check("arst_edge.rvalid", {15'd0, bus.rvalid}, '0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    for (int i = 0; i < NREG; i += 2) begin
      step("post_rst", 1'b0, 3'd0, 16'h0000, 1'b1, ASIZE'(i), ASIZE'(i + 1));
    end

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      step("rand", 1'($urandom_range(0, 1)), ASIZE'($urandom_range(0, NREG - 1)),
           DSIZE'($urandom), 1'($urandom_range(0, 3) != 0),
           ASIZE'($urandom_range(0, NREG - 1)), ASIZE'($urandom_range(0, NREG - 1)));
    end

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- Architectural register file at the consuming end of the EXE/WB writeback path.
- Accepts the writeback address/data pair and a write enable, and stores the value.
- Serves two read ports (operands A and B) to the decode stage through registered outputs.
- Write-first bypass ensures a same-cycle writeback is visible to a same-cycle read.

Parameters:
- DSIZE, 16, data width of each register (from define.v)
- ASIZE, 3, register address width; NREG = 2**ASIZE registers (from define.v)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- wen  input  1  writeback enable
- waddr  input  ASIZE  writeback destination register
- wdata  input  DSIZE  writeback data (ALU result from WB stage)
- ren  input  1  read request from decode stage
- raddr_a  input  ASIZE  operand A source register
- raddr_b  input  ASIZE  operand B source register
- rdata_a  output  DSIZE  registered operand A
- rdata_b  output  DSIZE  registered operand B
- rvalid  output  1  high for one cycle when rdata_a/rdata_b were updated by a read

Behaviour:
- Reset:
  - Asynchronous, active-high: on rst high, all NREG registers, rdata_a, rdata_b and rvalid go to 0 immediately, independent of clk.
  - While rst is high, no writes or reads take effect.
  - Reset asserted mid-operation discards any in-flight write or read that cycle.
- Register 0 is hardwired to zero:
  - Writes to address 0 are ignored.
  - Reads of address 0 always return 0, including under bypass.
- Write (rising edge, rst low): if wen=1 and waddr!=0, then mem[waddr] <= wdata. Otherwise the storage is unchanged.
- Read (rising edge, rst low, ren=1):
  - rdata_a <= value of raddr_a, where:
    - 0 if raddr_a=0;
    - else wdata if wen=1 and waddr=raddr_a (write-first bypass);
    - else mem[raddr_a].
  - rdata_b is computed identically from raddr_b.
  - rvalid <= 1.
- ren=0 on the rising edge: rdata_a/rdata_b hold their previous values, and rvalid <= 0.
- Latency: one cycle from ren sampled high to rdata_*/rvalid valid. A write is readable from storage on the following edge; same-edge reads see it via bypass.
- Throughput: one read and one write per cycle, back-to-back, with no stalls.
- Simultaneous events:
  - raddr_a = raddr_b = waddr with wen=1: both ports return wdata.
  - wen=1 and ren=0: the write completes and the outputs hold.
- Width rules: no arithmetic; all data passes through unmodified at DSIZE bits. Addresses are full-range 0..NREG-1, with no out-of-range case.
- No X propagation: all storage is initialised by reset.

Test Plan:
- Reset: drive writes, then pulse rst between clock edges. Required response:
  - rdata_a, rdata_b and rvalid go to 0 before the next edge.
  - Subsequent reads of every address return 0.
- Basic write/read:
  - Write 16'hA5A5 to r3 at edge N, with ren=0.
  - At edge N+1, ren=1, raddr_a=3, raddr_b=0.
  - Required: after N+1, rdata_a=16'hA5A5, rdata_b=0, rvalid=1.
- Bypass: at the same edge drive wen=1, waddr=5, wdata=16'h1234, ren=1, raddr_a=5, raddr_b=5 (r5 previously 16'h0042). Required: rdata_a=rdata_b=16'h1234 after that edge.
- r0 protection: write 16'hFFFF to r0, then read raddr_a=0, including the same-cycle bypass case. Required: rdata_a=0 in both cases.
- Hold and rvalid:
  - Read r3 (=16'hA5A5) with ren=1, then deassert ren for 3 cycles while writing r3=16'h0001.
  - Required: rdata_a stays 16'hA5A5 and rvalid=0 during the hold.
  - Next ren=1 read of r3 returns 16'h0001 with rvalid=1.
- Full sweep:
  - Write r1..r7 with values 16'h1111 x index, back-to-back.
  - Then read pairs (1,7), (2,6), (3,5) on consecutive cycles.
  - Required: each pair matches the written values one cycle after its request.
